task1: RTL and testbench



---
 rtl/task1.sv | 74 +++++++
 tb/tb_task1.sv | 137 +++++++++++++
 2 files changed

// File: rtl/task1.sv
// Two-stage pipelined signed complex multiplier: (op_1 + j*op_2) * (op_3 + j*op_4).
// Define TASK1_SAT_EN to saturate REAL/IMAG to 16 bits instead of wrapping.
module task1 (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [7:0]  op_1,
  input  logic signed [7:0]  op_2,
  input  logic signed [7:0]  op_3,
  input  logic signed [7:0]  op_4,
  output logic               out_valid,
  output logic signed [15:0] REAL_PART_NUM,
  output logic signed [15:0] IMAG_PART_NUM
);

  localparam int STAGES = 2;

  logic [STAGES:1]    vld_pipe_q;
  logic signed [15:0] p11_q, p22_q, p14_q, p23_q;
  logic signed [15:0] p11_d, p22_d, p14_d, p23_d;
  logic signed [16:0] re_sum, im_sum;
  logic signed [15:0] re_d, im_d, re_q, im_q;

  always_comb begin
    p11_d = 16'(op_1 * op_3);
    p22_d = 16'(op_2 * op_4);
    p14_d = 16'(op_1 * op_4);
    p23_d = 16'(op_2 * op_3);
  end

  // 17-bit sums so the single overflow case (+32768) is visible before reduction
  always_comb begin
    re_sum = {p11_q[15], p11_q} - {p22_q[15], p22_q};
    im_sum = {p14_q[15], p14_q} + {p23_q[15], p23_q};
`ifdef TASK1_SAT_EN
    if (re_sum[16] != re_sum[15]) re_d = re_sum[16] ? 16'sh8000 : 16'sh7FFF;
    else                          re_d = re_sum[15:0];
    if (im_sum[16] != im_sum[15]) im_d = im_sum[16] ? 16'sh8000 : 16'sh7FFF;
    else                          im_d = im_sum[15:0];
`else
    re_d = re_sum[15:0];
    im_d = im_sum[15:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      p11_q      <= '0;
      p22_q      <= '0;
      p14_q      <= '0;
      p23_q      <= '0;
      re_q       <= '0;
      im_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid) begin
        p11_q <= p11_d;
        p22_q <= p22_d;
        p14_q <= p14_d;
        p23_q <= p23_d;
      end
      if (vld_pipe_q[1]) begin
        re_q <= re_d;
        im_q <= im_d;
      end
    end
  end

  assign out_valid     = vld_pipe_q[STAGES];
  assign REAL_PART_NUM = re_q;
  assign IMAG_PART_NUM = im_q;

endmodule

// File: tb/tb_task1.sv
// Directed-vector bench for task1; expected results hand-computed from a1*b1-a2*b2 / a1*b2+a2*b1.
module tb_task1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [7:0]  op_1, op_2, op_3, op_4;
  logic               out_valid;
  logic signed [15:0] REAL_PART_NUM, IMAG_PART_NUM;

  int n_chk = 0;
  int n_err = 0;

  task1 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .op_1(op_1), .op_2(op_2), .op_3(op_3), .op_4(op_4),
    .out_valid(out_valid), .REAL_PART_NUM(REAL_PART_NUM), .IMAG_PART_NUM(IMAG_PART_NUM)
  );

  always #5 clk = ~clk;

`ifdef TASK1_SAT_EN
  localparam logic [15:0] IMAG_ALLNEG = 16'h7FFF;
`else
  localparam logic [15:0] IMAG_ALLNEG = 16'h8000;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic res(input string tag, input logic v, input logic [15:0] re, input logic [15:0] im);
    chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
    chk({tag, ".real"}, REAL_PART_NUM, re);
    chk({tag, ".imag"}, IMAG_PART_NUM, im);
  endtask

  task automatic drive(input logic v, input int a, input int b, input int c, input int d);
    in_valid = v;
    op_1 = 8'(a); op_2 = 8'(b); op_3 = 8'(c); op_4 = 8'(d);
  endtask

  initial begin
    // reset held with in_valid high and random operands
    rst = 1'b1;
    drive(1'b1, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      res("reset", 1'b0, 16'h0000, 16'h0000);
      drive(1'b1, $urandom, $urandom, $urandom, $urandom);
    end
    rst = 1'b0;
    drive(1'b0, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      res("post_reset", 1'b0, 16'h0000, 16'h0000);
    end

    // single op
    drive(1'b1, 1, 9, 34, 6);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0);
    chk("single.early", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    res("single", 1'b1, 16'hFFEC, 16'h0138);
    @(negedge clk);
    res("single.after", 1'b0, 16'hFFEC, 16'h0138);

    // back-to-back
    drive(1'b1, 1, 9, 34, 6);
    @(negedge clk);
    chk("b2b.early", {15'd0, out_valid}, 16'd0);
    drive(1'b1, 2, 10, 3, 17);
    @(negedge clk);
    res("b2b0", 1'b1, 16'hFFEC, 16'h0138);
    drive(1'b1, 67, 35, 67, 19);
    @(negedge clk);
    res("b2b1", 1'b1, 16'hFF5C, 16'h0040);
    drive(1'b0, 5, 5, 5, 5);
    @(negedge clk);
    res("b2b2", 1'b1, 16'h0EF0, 16'h0E22);
    @(negedge clk);
    res("b2b.end", 1'b0, 16'h0EF0, 16'h0E22);

    // signed corners: all -128, then 127*127 - (-128*127) = 32385, 127*127 + (-128*127) = -127
    drive(1'b1, -128, -128, -128, -128);
    @(negedge clk);
    drive(1'b1, 127, -128, 127, 127);
    @(negedge clk);
    res("allneg", 1'b1, 16'h0000, IMAG_ALLNEG);
    drive(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    res("maxmix", 1'b1, 16'h7E81, 16'hFF81);
    @(negedge clk);
    res("corner.end", 1'b0, 16'h7E81, 16'hFF81);

    // hold/bubble: operands change while in_valid is low; (-3+4j)*(5-7j) = 13+41j
    drive(1'b1, -3, 4, 5, -7);
    @(negedge clk);
    drive(1'b0, 100, -50, 77, 12);
    @(negedge clk);
    res("bubble", 1'b1, 16'h000D, 16'h0029);
    drive(1'b0, -9, 33, -1, 90);
    @(negedge clk);
    res("bubble.hold1", 1'b0, 16'h000D, 16'h0029);
    @(negedge clk);
    res("bubble.hold2", 1'b0, 16'h000D, 16'h0029);

    // mid-flight reset discards the in-flight op
    drive(1'b1, 10, 20, 30, 40);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    res("midrst", 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      res("midrst.after", 1'b0, 16'h0000, 16'h0000);
    end

    // recovery after reset: (10+20j)*(30+40j) = -500+1000j
    drive(1'b1, 10, 20, 30, 40);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    res("recover", 1'b1, 16'hFE0C, 16'h03E8);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
